// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded operands/control, forwards
// from EX/MEM and MEM/WB, and flags load-use hazards. Forwarding enabled by ID_EX_FORWARD_EN.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [15:0]       imm,
    input  logic              alu_src,
    input  logic [SEL_W-1:0]  alu_sel_in,
    input  logic              reg_write_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              mem_to_reg_in,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic [DATA_W-1:0] exmem_res,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    output logic [DATA_W-1:0] store_data,
    output logic [REG_AW-1:0] rd_out,
    output logic              reg_write_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic              mem_to_reg_out,
    output logic              out_valid,
    output logic              load_use
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs_addr;
        logic [REG_AW-1:0] rt_addr;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [15:0]       imm;
        logic              alu_src;
        logic [SEL_W-1:0]  alu_sel;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } stage_t;

    stage_t            stage_q;
    stage_t            stage_d;
    logic [DATA_W-1:0] imm_ext_s;
    logic [DATA_W-1:0] fwd_rs_s;
    logic [DATA_W-1:0] fwd_rt_s;
    logic              load_use_s;

    assign imm_ext_s = {{(DATA_W-16){stage_q.imm[15]}}, stage_q.imm};

`ifdef ID_EX_FORWARD_EN
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] stored,
        input logic              ex_we,
        input logic [REG_AW-1:0] ex_rd,
        input logic [DATA_W-1:0] ex_res,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_rd,
        input logic [DATA_W-1:0] wb_data
    );
        logic [DATA_W-1:0] r;
        if (ex_we && (ex_rd != {REG_AW{1'b0}}) && (ex_rd == src)) begin
            r = ex_res;
        end else if (wb_we && (wb_rd != {REG_AW{1'b0}}) && (wb_rd == src)) begin
            r = wb_data;
        end else begin
            r = stored;
        end
        return r;
    endfunction

    // Operand forwarding and load-use detection
    always_comb begin
        fwd_rs_s = fwd_sel(stage_q.rs_addr, stage_q.rs_data, exmem_reg_write, exmem_rd,
                           exmem_res, memwb_reg_write, memwb_rd, memwb_data);
        fwd_rt_s = fwd_sel(stage_q.rt_addr, stage_q.rt_data, exmem_reg_write, exmem_rd,
                           exmem_res, memwb_reg_write, memwb_rd, memwb_data);
        load_use_s = stage_q.valid && stage_q.mem_read && (stage_q.rd != {REG_AW{1'b0}})
                     && in_valid && ((stage_q.rd == rs_addr) || (stage_q.rd == rt_addr));
    end
`else
    logic unused_s;

    // Without forwarding the stored register data drives the ALU directly
    always_comb begin
        fwd_rs_s   = stage_q.rs_data;
        fwd_rt_s   = stage_q.rt_data;
        load_use_s = 1'b0;
    end

    assign unused_s = ^{exmem_rd, exmem_reg_write, exmem_res, memwb_rd, memwb_reg_write,
                        memwb_data, stage_q.rs_addr, stage_q.rt_addr};
`endif

    // Next-state: flush > stall > load-use bubble > capture
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (stall) begin
            stage_d = stage_q;
        end else if (load_use_s) begin
            stage_d = '0;
        end else begin
            stage_d.valid      = in_valid;
            stage_d.rs_addr    = rs_addr;
            stage_d.rt_addr    = rt_addr;
            stage_d.rd         = rd_addr;
            stage_d.rs_data    = rs_data;
            stage_d.rt_data    = rt_data;
            stage_d.imm        = imm;
            stage_d.alu_src    = alu_src;
            stage_d.alu_sel    = in_valid ? alu_sel_in : {SEL_W{1'b0}};
            stage_d.reg_write  = in_valid & reg_write_in;
            stage_d.mem_read   = in_valid & mem_read_in;
            stage_d.mem_write  = in_valid & mem_write_in;
            stage_d.mem_to_reg = in_valid & mem_to_reg_in;
        end
    end

    // Stage register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign alu_a          = fwd_rs_s;
    assign alu_b          = stage_q.alu_src ? imm_ext_s : fwd_rt_s;
    assign store_data     = fwd_rt_s;
    assign alu_sel        = stage_q.alu_sel;
    assign rd_out         = stage_q.rd;
    assign reg_write_out  = stage_q.reg_write;
    assign mem_read_out   = stage_q.mem_read;
    assign mem_write_out  = stage_q.mem_write;
    assign mem_to_reg_out = stage_q.mem_to_reg;
    assign out_valid      = stage_q.valid;
    assign load_use       = load_use_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push expected outputs, a negedge
// monitor pops and compares. Expectations follow ID_EX_FORWARD_EN when it is defined.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm;
    logic        alu_src;
    logic [3:0]  alu_sel_in;
    logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_res, memwb_data;
    logic [31:0] alu_a, alu_b, store_data;
    logic [3:0]  alu_sel;
    logic [4:0]  rd_out;
    logic        reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out;
    logic        out_valid, load_use;

    typedef struct packed {
        logic        v;
        logic [3:0]  ctrl;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        lu;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] st;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .alu_src(alu_src),
        .alu_sel_in(alu_sel_in), .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_res(exmem_res),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_data(memwb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .store_data(store_data),
        .rd_out(rd_out), .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .mem_to_reg_out(mem_to_reg_out),
        .out_valid(out_valid), .load_use(load_use)
    );

    // Monitor: compare every pending expectation against the DUT mid-cycle
    always @(negedge clk) begin
        obs_t  e;
        obs_t  act;
        string nm;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act.v    = out_valid;
            act.ctrl = {reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out};
            act.sel  = alu_sel;
            act.rd   = rd_out;
            act.lu   = load_use;
            act.a    = alu_a;
            act.b    = alu_b;
            act.st   = store_data;
            n_vec++;
            if (act !== e) begin
                n_err++;
                $display("FAIL %s: got v=%b ctrl=%b sel=%h rd=%0d lu=%b a=%h b=%h st=%h, required v=%b ctrl=%b sel=%h rd=%0d lu=%b a=%h b=%h st=%h",
                         nm, act.v, act.ctrl, act.sel, act.rd, act.lu, act.a, act.b, act.st,
                         e.v, e.ctrl, e.sel, e.rd, e.lu, e.a, e.b, e.st);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic v, input logic [3:0] ctrl,
                              input logic [3:0] sel, input logic [4:0] rd, input logic lu,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] st);
        obs_t e;
        e = '{v: v, ctrl: ctrl, sel: sel, rd: rd, lu: lu, a: a, b: b, st: st};
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; rs_addr = 5'd0; rt_addr = 5'd0; rd_addr = 5'd0;
        rs_data = 32'd0; rt_data = 32'd0; imm = 16'd0; alu_src = 1'b0; alu_sel_in = 4'd0;
        reg_write_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; mem_to_reg_in = 1'b0;
        exmem_rd = 5'd0; exmem_reg_write = 1'b0; exmem_res = 32'd0;
        memwb_rd = 5'd0; memwb_reg_write = 1'b0; memwb_data = 32'd0;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                         input logic [31:0] rtd, input logic [15:0] im, input logic src,
                         input logic [3:0] sel, input logic [4:0] rd, input logic [3:0] ctrl);
        in_valid = 1'b1; rs_addr = rs; rs_data = rsd; rt_addr = rt; rt_data = rtd;
        imm = im; alu_src = src; alu_sel_in = sel; rd_addr = rd;
        {reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in} = ctrl;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, required finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        idle();
        tick();
        tick();
        // Reset with nonzero inputs
        drive(5'd1, 32'hDEAD, 5'd2, 32'hBEEF, 16'h1234, 1'b1, 4'h3, 5'd7, 4'b1111);
        tick();
        rst = 1'b0;
        idle();
        expect_out("reset", 1'b0, 4'b0000, 4'h0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);

        // Basic capture
        drive(5'd1, 32'd5, 5'd2, 32'd7, 16'd0, 1'b0, 4'h1, 5'd3, 4'b1000);
        tick();
        idle();
        expect_out("capture", 1'b1, 4'b1000, 4'h1, 5'd3, 1'b0, 32'd5, 32'd7, 32'd7);

        // Immediate sign extension
        drive(5'd1, 32'd5, 5'd2, 32'd7, 16'hFFFC, 1'b1, 4'h1, 5'd3, 4'b1000);
        tick();
        idle();
        expect_out("imm_neg", 1'b1, 4'b1000, 4'h1, 5'd3, 1'b0, 32'd5, 32'hFFFF_FFFC, 32'd7);
        drive(5'd1, 32'd5, 5'd2, 32'd7, 16'h0010, 1'b1, 4'h1, 5'd3, 4'b1000);
        tick();
        idle();
        expect_out("imm_pos", 1'b1, 4'b1000, 4'h1, 5'd3, 1'b0, 32'd5, 32'h0000_0010, 32'd7);

        // Forwarding priority, stage held by stall while bypass inputs change
        drive(5'd4, 32'h11, 5'd5, 32'h22, 16'd0, 1'b0, 4'h2, 5'd6, 4'b1000);
        tick();
        stall = 1'b1;
        idle();
        exmem_rd = 5'd4; exmem_res = 32'hAA; exmem_reg_write = 1'b1;
        memwb_rd = 5'd4; memwb_data = 32'hBB; memwb_reg_write = 1'b1;
        expect_out("fwd_exmem", 1'b1, 4'b1000, 4'h2, 5'd6, 1'b0,
                   FWD ? 32'hAA : 32'h11, 32'h22, 32'h22);
        tick();
        exmem_reg_write = 1'b0;
        expect_out("fwd_memwb", 1'b1, 4'b1000, 4'h2, 5'd6, 1'b0,
                   FWD ? 32'hBB : 32'h11, 32'h22, 32'h22);
        tick();
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        expect_out("fwd_r0", 1'b1, 4'b1000, 4'h2, 5'd6, 1'b0, 32'h11, 32'h22, 32'h22);
        tick();
        exmem_reg_write = 1'b0; memwb_rd = 5'd5; memwb_data = 32'hCC;
        expect_out("fwd_rt", 1'b1, 4'b1000, 4'h2, 5'd6, 1'b0, 32'h11,
                   FWD ? 32'hCC : 32'h22, FWD ? 32'hCC : 32'h22);
        stall = 1'b0;
        idle();

        // Load-use: lw r8 in stage, dependent add in ID
        drive(5'd1, 32'h100, 5'd8, 32'd0, 16'd4, 1'b1, 4'h1, 5'd8, 4'b1101);
        tick();
        drive(5'd8, 32'h999, 5'd2, 32'h7, 16'd0, 1'b0, 4'h1, 5'd9, 4'b1000);
        expect_out("lu_detect", 1'b1, 4'b1101, 4'h1, 5'd8, FWD, 32'h100, 32'd4, 32'd0);
        tick();
        if (FWD) begin
            expect_out("lu_bubble", 1'b0, 4'b0000, 4'h0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        end else begin
            expect_out("lu_bubble", 1'b1, 4'b1000, 4'h1, 5'd9, 1'b0, 32'h999, 32'h7, 32'h7);
        end
        tick();
        memwb_rd = 5'd8; memwb_data = 32'h1234; memwb_reg_write = 1'b1;
        expect_out("lu_forward", 1'b1, 4'b1000, 4'h1, 5'd9, 1'b0,
                   FWD ? 32'h1234 : 32'h999, 32'h7, 32'h7);
        idle();

        // Stall holds for three cycles with changing inputs, then stall+flush bubbles
        drive(5'd1, 32'h55, 5'd2, 32'h66, 16'd0, 1'b0, 4'h9, 5'd10, 4'b1010);
        tick();
        idle();
        expect_out("pre_stall", 1'b1, 4'b1010, 4'h9, 5'd10, 1'b0, 32'h55, 32'h66, 32'h66);
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            drive(5'd3, 32'h1000 + 32'(i), 5'd4, 32'h2000 + 32'(i), 16'h00FF, 1'b1,
                  4'hF, 5'(i + 1), 4'b0101);
            tick();
            expect_out("stall_hold", 1'b1, 4'b1010, 4'h9, 5'd10, 1'b0, 32'h55, 32'h66, 32'h66);
        end
        flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0;
        idle();
        expect_out("stall_flush", 1'b0, 4'b0000, 4'h0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);

        // in_valid=0 captures a bubble: control and select forced low
        drive(5'd1, 32'h77, 5'd2, 32'h88, 16'd0, 1'b0, 4'h5, 5'd4, 4'b1100);
        in_valid = 1'b0;
        tick();
        idle();
        expect_out("bubble_capture", 1'b0, 4'b0000, 4'h0, 5'd4, 1'b0, 32'h77, 32'h88, 32'h88);

        // Reset during a stall clears the stage
        drive(5'd1, 32'h33, 5'd2, 32'h44, 16'd0, 1'b0, 4'h3, 5'd5, 4'b1000);
        tick();
        stall = 1'b1; rst = 1'b1;
        tick();
        stall = 1'b0; rst = 1'b0;
        idle();
        expect_out("rst_in_stall", 1'b0, 4'b0000, 4'h0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);

        tick();
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
